// File: rtl/dica_pkg.sv
// Shared constants, FSM encoding and address helper for the checkpoint copy engine
// and the dirty-block tracker that feeds it.
package dica_pkg;

  localparam logic [15:0] DMEM_BASE = 16'h0200;
  localparam int          DMEM_SIZE = 1024;
  localparam int          BLK_SIZE  = 128;
  localparam logic [15:0] NVM_BASE  = 16'hC000;

  localparam int TOTAL_BLOCKS  = DMEM_SIZE / BLK_SIZE;
  localparam int WORDS_PER_BLK = BLK_SIZE / 2;
  localparam int BLK_W         = (TOTAL_BLOCKS > 1) ? $clog2(TOTAL_BLOCKS) : 1;
  localparam int BLK_MSB       = BLK_W - 1;
  localparam int WORD_W        = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
  localparam int WORD_MSB      = WORD_W - 1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SCAN  = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_CAPT  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_CLEAR = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_SCAN  = ST_SCAN,
    S_READ  = ST_READ,
    S_CAPT  = ST_CAPT,
    S_WRITE = ST_WRITE,
    S_CLEAR = ST_CLEAR,
    S_DONE  = ST_DONE
  } state_e;

  // Byte offset of a word inside the DMEM image; identical for the DMEM and NVM sides.
  function automatic logic [15:0] blkOffset(input logic [BLK_MSB:0] blk,
                                            input logic [WORD_MSB:0] word);
    logic [15:0] blkPart;
    logic [15:0] wordPart;
    blkPart  = 16'(blk) * 16'(BLK_SIZE);
    wordPart = 16'(word) << 1;
    return blkPart + wordPart;
  endfunction

endpackage

// File: rtl/dica_prio_enc.sv
// Lowest-set-bit encoder: reports the index of the lowest set bit and whether any bit is set.
module dica_prio_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan from the top down so the last hit, the lowest index, wins.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dica_ckpt_engine.sv
// Checkpoint copy engine: snapshots the dirty bitmap and mirrors each dirty DMEM block
// word by word into the NVM backup image, clearing each block once it is saved.
module dica_ckpt_engine
  import dica_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [TOTAL_BLOCKS-1:0] d_table,
  output logic                    busy,
  output logic                    done,
  output logic [TOTAL_BLOCKS-1:0] blk_clr,
  output logic [15:0]             blocks_saved,
  output logic [15:0]             dmem_addr,
  output logic                    dmem_rd,
  input  logic [15:0]             dmem_rdata,
  output logic [15:0]             nvm_addr,
  output logic [15:0]             nvm_wdata,
  output logic                    nvm_wr,
  input  logic                    nvm_ready
);

  localparam logic [WORD_MSB:0] WORD_LAST = WORD_W'(WORDS_PER_BLK - 1);

  state_e                  state_q, state_d;
  logic [TOTAL_BLOCKS-1:0] snap_q, snap_d;
  logic [BLK_MSB:0]        blk_q, blk_d;
  logic [WORD_MSB:0]       word_q, word_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    busy_q, busy_d;
  logic [15:0]             saved_q, saved_d;

  logic [BLK_MSB:0]        lowIdx;
  logic                    anySet;
  logic [TOTAL_BLOCKS-1:0] blkOneHot;
  logic [15:0]             offset;

  dica_prio_enc #(
    .WIDTH(TOTAL_BLOCKS),
    .IDX_W(BLK_W)
  ) u_prio_enc (
    .vec_i(snap_q),
    .idx_o(lowIdx),
    .any_o(anySet)
  );

  assign blkOneHot = TOTAL_BLOCKS'(1) << blk_q;
  assign offset    = blkOffset(blk_q, word_q);

  assign busy         = busy_q;
  assign blocks_saved = saved_q;
  assign nvm_wdata    = wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      blk_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      blk_q   <= blk_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      saved_q <= saved_d;
    end
  end

  // Memory strobes and addresses are gated by state so everything reads 0 outside its phase.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    blk_d     = blk_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    busy_d    = busy_q;
    saved_d   = saved_q;
    dmem_rd   = 1'b0;
    dmem_addr = '0;
    nvm_wr    = 1'b0;
    nvm_addr  = '0;
    done      = 1'b0;
    blk_clr   = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          snap_d  = d_table;
          saved_d = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!anySet) begin
          state_d = S_DONE;
        end else begin
          blk_d   = lowIdx;
          word_d  = '0;
          state_d = S_READ;
        end
      end

      S_READ: begin
        dmem_rd   = 1'b1;
        dmem_addr = DMEM_BASE + offset;
        state_d   = S_CAPT;
      end

      S_CAPT: begin
        wdata_d = dmem_rdata;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        nvm_wr   = 1'b1;
        nvm_addr = NVM_BASE + offset;
        if (nvm_ready) begin
          if (word_q == WORD_LAST) begin
            state_d = S_CLEAR;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = S_READ;
          end
        end
      end

      S_CLEAR: begin
        blk_clr = blkOneHot;
        snap_d  = snap_q & ~blkOneHot;
        saved_d = (saved_q == 16'hFFFF) ? saved_q : saved_q + 16'd1;
        state_d = S_SCAN;
      end

      S_DONE: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dica_ckpt_engine.sv
// Self-checking bench for dica_ckpt_engine: directed and randomized checkpoints checked
// against a transaction-level model of the expected DMEM reads, NVM writes and clears.
module tb_dica_ckpt_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  d_table = 8'h00;
  logic        busy;
  logic        done;
  logic [7:0]  blk_clr;
  logic [15:0] blocks_saved;
  logic [15:0] dmem_addr;
  logic        dmem_rd;
  logic [15:0] dmem_rdata = 16'h0000;
  logic [15:0] nvm_addr;
  logic [15:0] nvm_wdata;
  logic        nvm_wr;
  logic        nvm_ready;

  always #5 clk = ~clk;

  dica_ckpt_engine dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .d_table     (d_table),
    .busy        (busy),
    .done        (done),
    .blk_clr     (blk_clr),
    .blocks_saved(blocks_saved),
    .dmem_addr   (dmem_addr),
    .dmem_rd     (dmem_rd),
    .dmem_rdata  (dmem_rdata),
    .nvm_addr    (nvm_addr),
    .nvm_wdata   (nvm_wdata),
    .nvm_wr      (nvm_wr),
    .nvm_ready   (nvm_ready)
  );

  // DMEM model: word array, read data returned one cycle after the strobe.
  logic [15:0] mem [0:511];
  always @(posedge clk) begin
    if (dmem_rd) dmem_rdata <= mem[9'((dmem_addr - 16'h0200) >> 1)];
  end

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // NVM acceptance: optional random backpressure plus a targeted 5-cycle stall.
  logic        baseReady = 1'b1;
  logic        randReady = 1'b0;
  logic        stallArm = 1'b0;
  logic [15:0] stallAddr = 16'hC094;
  int          stallCnt = 0;
  logic        stallNow;

  always @(posedge clk) baseReady <= randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
  assign stallNow  = stallArm && nvm_wr && (nvm_addr == stallAddr) && (stallCnt < 5);
  always @(posedge clk) if (stallNow) stallCnt <= stallCnt + 1;
  assign nvm_ready = baseReady && !stallNow;

  // Transaction monitor, sampled on the falling edge.
  logic [15:0] rdQ [$];
  logic [31:0] wrQ [$];
  logic [7:0]  clrQ [$];
  int          doneCount = 0;
  int          stallTotal = 0;
  int          unstable = 0;
  logic        prevStall = 1'b0;
  logic [15:0] prevAddr = 16'h0;
  logic [15:0] prevData = 16'h0;

  always @(negedge clk) begin
    if (dmem_rd) rdQ.push_back(dmem_addr);
    if (nvm_wr && nvm_ready) wrQ.push_back({nvm_addr, nvm_wdata});
    if (blk_clr != 8'h00) clrQ.push_back(blk_clr);
    if (done) doneCount++;
    if (nvm_wr && prevStall && ((nvm_addr != prevAddr) || (nvm_wdata != prevData))) unstable++;
    if (nvm_wr && !nvm_ready) stallTotal++;
    prevStall = nvm_wr && !nvm_ready;
    prevAddr  = nvm_addr;
    prevData  = nvm_wdata;
  end

  int assertCount = 0;
  int failCount = 0;
  int acceptAt;
  int doneAt;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clearMon();
    rdQ.delete();
    wrQ.delete();
    clrQ.delete();
    doneCount  = 0;
    stallTotal = 0;
    unstable   = 0;
  endtask

  task automatic fillMem();
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkEq({tag, "_busy"}, 32'(busy), 32'd0);
    checkEq({tag, "_done"}, 32'(done), 32'd0);
    checkEq({tag, "_blk_clr"}, 32'(blk_clr), 32'd0);
    checkEq({tag, "_blocks_saved"}, 32'(blocks_saved), 32'd0);
    checkEq({tag, "_dmem_rd"}, 32'(dmem_rd), 32'd0);
    checkEq({tag, "_dmem_addr"}, 32'(dmem_addr), 32'd0);
    checkEq({tag, "_nvm_wr"}, 32'(nvm_wr), 32'd0);
    checkEq({tag, "_nvm_addr"}, 32'(nvm_addr), 32'd0);
    checkEq({tag, "_nvm_wdata"}, 32'(nvm_wdata), 32'd0);
  endtask

  // Drive a start request in an IDLE cycle; that cycle is the acceptance cycle.
  task automatic applyStimulus(input logic [7:0] tbl, input bit hold);
    @(negedge clk);
    clearMon();
    d_table  = tbl;
    start    = 1'b1;
    acceptAt = cycleCnt;
    @(negedge clk);
    if (!hold) start = 1'b0;
    checkEq("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen   = 1'b0;
    doneAt = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) begin
        seen   = 1'b1;
        doneAt = cycleCnt;
        break;
      end
    end
    checkEq("done_seen", 32'(seen), 32'd1);
  endtask

  // Expected traffic: every snapshot block in ascending order, 64 words each.
  task automatic checkOutput(input logic [7:0] snap, input int accAt, input int dnAt,
                             input int extra);
    int nBlk;
    int k;
    int j;
    int failsBefore;
    logic [15:0] expRd;
    logic [31:0] expWr;
    nBlk = $countones(snap);
    checkEq("latency", 32'(dnAt - accAt), 32'(2 + nBlk * 194 + extra));
    @(negedge clk);
    checkEq("done_width", 32'(done), 32'd0);
    checkEq("busy_after_done", 32'(busy), 32'd0);
    checkEq("blocks_saved", 32'(blocks_saved), 32'(nBlk));
    checkEq("done_count", 32'(doneCount), 32'd1);
    checkEq("rd_count", 32'(rdQ.size()), 32'(nBlk * 64));
    checkEq("wr_count", 32'(wrQ.size()), 32'(nBlk * 64));
    checkEq("clr_count", 32'(clrQ.size()), 32'(nBlk));
    checkEq("nvm_stable", 32'(unstable), 32'd0);
    k = 0;
    j = 0;
    failsBefore = failCount;
    for (int b = 0; b < 8; b++) begin
      if (snap[b]) begin
        for (int w = 0; w < 64; w++) begin
          expRd = 16'h0200 + 16'(b * 128 + 2 * w);
          expWr = {16'hC000 + 16'(b * 128 + 2 * w), mem[b * 64 + w]};
          if ((k < rdQ.size()) && (failCount == failsBefore)) checkEq("rd_addr", 32'(rdQ[k]), 32'(expRd));
          if ((k < wrQ.size()) && (failCount == failsBefore)) checkEq("wr_addr_data", wrQ[k], expWr);
          k++;
        end
        if (j < clrQ.size()) checkEq("clr_order", 32'(clrQ[j]), 32'(8'd1 << b));
        j++;
      end
    end
    clearMon();
  endtask

  initial begin
    bit found;
    fillMem();

    // Reset state
    #23;
    checkIdleOutputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkIdleOutputs("idle");

    $display("[TB] single block 2");
    applyStimulus(8'b0000_0100, 1'b0);
    waitDone(3000);
    checkOutput(8'b0000_0100, acceptAt, doneAt, 0);

    $display("[TB] blocks 0 and 7");
    applyStimulus(8'b1000_0001, 1'b0);
    waitDone(3000);
    checkOutput(8'b1000_0001, acceptAt, doneAt, 0);

    $display("[TB] empty bitmap");
    applyStimulus(8'h00, 1'b0);
    waitDone(50);
    checkOutput(8'h00, acceptAt, doneAt, 0);

    $display("[TB] nvm backpressure on block 1 word 10");
    stallCnt = 0;
    stallArm = 1'b1;
    applyStimulus(8'b0000_0010, 1'b0);
    waitDone(3000);
    checkEq("stall_cycles", 32'(stallTotal), 32'd5);
    checkOutput(8'b0000_0010, acceptAt, doneAt, 5);
    stallArm = 1'b0;

    $display("[TB] bitmap grows while busy, start held");
    applyStimulus(8'h01, 1'b1);
    repeat (4) @(negedge clk);
    d_table = 8'h03;
    waitDone(3000);
    checkOutput(8'h01, acceptAt, doneAt, 0);
    acceptAt = doneAt + 1;
    @(negedge clk);
    checkEq("busy_restart", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone(3000);
    checkOutput(8'h03, acceptAt, doneAt, 0);

    $display("[TB] reset during block 3 word 20");
    applyStimulus(8'b0000_1000, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (nvm_wr && (nvm_addr == 16'hC1A8)) begin
        found = 1'b1;
        break;
      end
    end
    checkEq("reached_b3w20", 32'(found), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    repeat (3) @(negedge clk);
    checkEq("reset_no_clr", 32'(clrQ.size()), 32'd0);
    checkEq("reset_no_done", 32'(doneCount), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checkEq("post_reset_busy", 32'(busy), 32'd0);
    checkEq("post_reset_done", 32'(done), 32'd0);
    applyStimulus(8'b0000_1000, 1'b0);
    waitDone(3000);
    checkOutput(8'b0000_1000, acceptAt, doneAt, 0);

    $display("[TB] randomized bitmaps with random nvm_ready");
    randReady = 1'b1;
    for (int r = 0; r < 4; r++) begin
      logic [7:0] tbl;
      tbl = 8'($urandom);
      fillMem();
      applyStimulus(tbl, 1'b0);
      waitDone(4000);
      checkOutput(tbl, acceptAt, doneAt, stallTotal);
    end
    randReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
